// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the register-file write scheduler.
//   REG_ADDR_W    : register-file address width (32 architectural registers)
//   DATA_W        : register-file data width
//   rf_wr_t       : one register-file write {destination, data}
//   sched_state_t : starvation-guard states of the write scheduler
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wn;
    logic [DATA_W-1:0]     wd;
  } rf_wr_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    AGING  = 2'd1,
    FORCE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bundle of all non-clock signals around the register-file write scheduler.
//   wb_*       : writeback-stage write request (valid, dest, data)
//   lu_issue*  : long-latency op issued, with its destination
//   lu_valid/lu_wn/lu_wd/lu_ready : long-latency result handshake
//   id_rn1/id_rn2/id_wn, id_stall : decode hazard query and stall
//   rf_we/rf_wn/rf_wd : register-file write port
// master = surrounding pipeline, slave = scheduler.
interface regfile_wr_sched_if;
  import cpu_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_wn;
  logic [DATA_W-1:0]     wb_wd;

  logic                  lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_wn;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_wn;
  logic [DATA_W-1:0]     lu_wd;
  logic                  lu_ready;

  logic [REG_ADDR_W-1:0] id_rn1;
  logic [REG_ADDR_W-1:0] id_rn2;
  logic [REG_ADDR_W-1:0] id_wn;
  logic                  id_stall;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_wn;
  logic [DATA_W-1:0]     rf_wd;

  modport master (
    output wb_valid, wb_wn, wb_wd,
    output lu_issue, lu_issue_wn, lu_valid, lu_wn, lu_wd,
    output id_rn1, id_rn2, id_wn,
    input  lu_ready, id_stall, rf_we, rf_wn, rf_wd
  );

  modport slave (
    input  wb_valid, wb_wn, wb_wd,
    input  lu_issue, lu_issue_wn, lu_valid, lu_wn, lu_wd,
    input  id_rn1, id_rn2, id_wn,
    output lu_ready, id_stall, rf_we, rf_wn, rf_wd
  );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO of register-file writes buffering long-latency results.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write an entry (ignored when full)
//   pop, dout  : head entry, removed on pop (ignored when empty)
//   full, empty, count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module regfile_wr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  rf_wr_t                   din,
  input  logic                     pop,
  output rf_wr_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rf_wr_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage carries no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler and long-latency scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wr_sched_if.slave (WB request, long-latency issue and
//                result handshake, decode hazard query/stall, RF write port)
// WB writes own the port; buffered long-latency results drain when WB is idle
// or writes r0. Registers with an outstanding long-latency write stall decode,
// and a result head left waiting STARVE_LIMIT cycles stalls decode so the WB
// slot empties and the head can drain.
module regfile_wr_sched
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wr_sched_if.slave  bus
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  rf_wr_t             lu_ent;
  rf_wr_t             head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               wb_take;
  logic               push;
  logic               pop;
  logic               head_left;

  logic [31:1]        pending;
  logic [31:1]        pending_nxt;
  logic               hazard;

  sched_state_t       state_q;
  sched_state_t       state_d;
  logic [AGE_W-1:0]   age_q;
  logic [AGE_W-1:0]   age_d;

  function automatic logic reg_pending(input logic [31:1] pv,
                                       input logic [REG_ADDR_W-1:0] rn);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (rn == REG_ADDR_W'(i)) hit = pv[i];
    end
    return hit;
  endfunction

  assign lu_ent  = {bus.lu_wn, bus.lu_wd};
  assign wb_take = bus.wb_valid && (bus.wb_wn != '0);
  assign pop     = !empty && !wb_take;
  assign push    = bus.lu_valid && !full;
  // Something remains at the head after this cycle's pop.
  assign head_left = (count > CNT_W'(1)) || push;

  assign bus.lu_ready = !full;

  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (lu_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Write port: WB first, then FIFO head; a head aimed at r0 pops silently.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wn = '0;
    bus.rf_wd = '0;
    if (wb_take) begin
      bus.rf_we = 1'b1;
      bus.rf_wn = bus.wb_wn;
      bus.rf_wd = bus.wb_wd;
    end else if (!empty && (head.wn != '0)) begin
      bus.rf_we = 1'b1;
      bus.rf_wn = head.wn;
      bus.rf_wd = head.wd;
    end
  end

  // Scoreboard: an issue on the same edge as a drain of that register wins.
  always_comb begin
    pending_nxt = pending;
    for (int i = 1; i < 32; i++) begin
      if (pop && (head.wn == REG_ADDR_W'(i))) pending_nxt[i] = 1'b0;
      if (bus.lu_issue && (bus.lu_issue_wn == REG_ADDR_W'(i))) pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hazard = reg_pending(pending, bus.id_rn1) ||
                  reg_pending(pending, bus.id_rn2) ||
                  reg_pending(pending, bus.id_wn);

  assign bus.id_stall = hazard || (state_q == FORCE);

  // Starvation guard: age counts cycles the current head has waited.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    if (pop) begin
      age_d   = '0;
      state_d = head_left ? AGING : NORMAL;
    end else if (empty) begin
      age_d   = '0;
      state_d = NORMAL;
    end else begin
      unique case (state_q)
        NORMAL: age_d = AGE_W'(1);
        AGING, FORCE: age_d = (age_q >= AGE_W'(STARVE_LIMIT)) ? age_q : age_q + 1'b1;
        default: age_d = '0;
      endcase
      state_d = (age_d >= AGE_W'(STARVE_LIMIT)) ? FORCE : AGING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: directed scenarios followed by
// randomized traffic, all checked against a queue/array reference model.
module tb_regfile_wr_sched;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic        wbv;
    logic [4:0]  wbn;
    logic [31:0] wbd;
    logic        iss;
    logic [4:0]  issn;
    logic        luv;
    logic [4:0]  lun;
    logic [31:0] lud;
    logic [4:0]  rn1;
    logic [4:0]  rn2;
    logic [4:0]  idwn;
  } stim_t;

  logic clk;
  logic rst_n;
  regfile_wr_sched_if bus ();

  regfile_wr_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  stim_t s;

  // Reference model: buffered results, outstanding registers, head wait time.
  rf_wr_t   mq[$];
  bit [31:0] mpend;
  int       mwait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    s = '{default: '0};
  endtask

  task automatic model_reset();
    mq.delete();
    mpend = '0;
    mwait = 0;
  endtask

  task automatic apply();
    bus.wb_valid    = s.wbv;
    bus.wb_wn       = s.wbn;
    bus.wb_wd       = s.wbd;
    bus.lu_issue    = s.iss;
    bus.lu_issue_wn = s.issn;
    bus.lu_valid    = s.luv;
    bus.lu_wn       = s.lun;
    bus.lu_wd       = s.lud;
    bus.id_rn1      = s.rn1;
    bus.id_rn2      = s.rn2;
    bus.id_wn       = s.idwn;
  endtask

  task automatic drive_chk();
    logic [31:0] e_we, e_wn, e_wd, e_rdy, e_stall;
    @(negedge clk);
    apply();
    #1;
    e_we = 0; e_wn = 0; e_wd = 0;
    if (s.wbv && s.wbn != 0) begin
      e_we = 1; e_wn = 32'(s.wbn); e_wd = s.wbd;
    end else if (mq.size() > 0 && mq[0].wn != 0) begin
      e_we = 1; e_wn = 32'(mq[0].wn); e_wd = mq[0].wd;
    end
    e_rdy   = 32'(mq.size() < DEPTH);
    e_stall = 32'(mpend[s.rn1] | mpend[s.rn2] | mpend[s.idwn] | (mwait >= LIMIT));
    chk("rf_we", 32'(bus.rf_we), e_we);
    chk("rf_wn", 32'(bus.rf_wn), e_wn);
    chk("rf_wd", bus.rf_wd, e_wd);
    chk("lu_ready", 32'(bus.lu_ready), e_rdy);
    chk("id_stall", 32'(bus.id_stall), e_stall);
  endtask

  task automatic tick();
    bit     pop, accept, was_ne;
    rf_wr_t h;
    @(posedge clk);
    was_ne = (mq.size() > 0);
    pop    = !(s.wbv && s.wbn != 0) && was_ne;
    accept = s.luv && (mq.size() < DEPTH);
    if (pop) begin
      h = mq.pop_front();
      if (h.wn != 0) mpend[h.wn] = 1'b0;
    end
    if (s.iss && s.issn != 0) mpend[s.issn] = 1'b1;
    if (accept) begin
      h.wn = s.lun;
      h.wd = s.lud;
      mq.push_back(h);
    end
    if (pop)         mwait = 0;
    else if (was_ne) mwait = (mwait < LIMIT) ? mwait + 1 : mwait;
    else             mwait = 0;
  endtask

  initial begin
    bit done;
    n_chk = 0;
    n_err = 0;
    clr();
    apply();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rst_id_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_wn", 32'(bus.rf_wn), 32'd0);
    chk("rst_rf_wd", bus.rf_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Issue to r5, decode stalls, result drains next cycle, stall drops after.
    clr(); s.iss = 1; s.issn = 5; drive_chk(); tick();
    clr(); s.rn1 = 5; drive_chk(); chk("t1_stall_set", 32'(bus.id_stall), 32'd1); tick();
    clr(); s.rn1 = 5; s.luv = 1; s.lun = 5; s.lud = 32'hDEADBEEF;
    drive_chk(); chk("t1_no_bypass", 32'(bus.rf_we), 32'd0); tick();
    clr(); s.rn1 = 5; drive_chk();
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_wn", 32'(bus.rf_wn), 32'd5);
    chk("t1_wd", bus.rf_wd, 32'hDEADBEEF);
    tick();
    clr(); s.rn1 = 5; drive_chk(); chk("t1_stall_clr", 32'(bus.id_stall), 32'd0); tick();

    // WB beats a waiting head; head drains once WB is idle.
    clr(); s.luv = 1; s.lun = 9; s.lud = 32'h99; drive_chk(); tick();
    clr(); s.wbv = 1; s.wbn = 3; s.wbd = 7; drive_chk();
    chk("t2_wb_wn", 32'(bus.rf_wn), 32'd3);
    chk("t2_wb_wd", bus.rf_wd, 32'd7);
    tick();
    clr(); drive_chk(); chk("t2_head_wn", 32'(bus.rf_wn), 32'd9); tick();

    // Fill FIFO while WB is busy; third result is held until space opens.
    clr(); s.wbv = 1; s.wbn = 1; s.luv = 1; s.lun = 11; s.lud = 1; drive_chk(); tick();
    s.lud = 2; drive_chk(); tick();
    s.lud = 3; drive_chk(); chk("t3_full", 32'(bus.lu_ready), 32'd0); tick();
    s.wbv = 0; drive_chk();
    chk("t3_pop1", bus.rf_wd, 32'd1);
    chk("t3_no_push_full", 32'(bus.lu_ready), 32'd0);
    tick();
    done = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      drive_chk();
      done = bus.lu_ready;
      tick();
    end
    chk("t3_accepted", 32'(done), 32'd1);
    clr(); drive_chk(); chk("t3_pop3", bus.rf_wd, 32'd3); tick();

    // Head starved by continuous WB writes forces a stall after LIMIT cycles.
    clr(); s.wbv = 1; s.wbn = 2; s.wbd = 5; s.luv = 1; s.lun = 12; s.lud = 32'h12;
    drive_chk(); tick();
    s.luv = 0;
    for (int k = 0; k < 6; k++) begin
      drive_chk();
      chk("t4_starve", 32'(bus.id_stall), 32'(k >= LIMIT));
      tick();
    end
    s.wbv = 0; drive_chk();
    chk("t4_drain_wn", 32'(bus.rf_wn), 32'd12);
    chk("t4_still_forced", 32'(bus.id_stall), 32'd1);
    tick();
    clr(); drive_chk(); chk("t4_released", 32'(bus.id_stall), 32'd0); tick();

    // WB to r0 leaves the port free; r0 never pending; head to r0 pops silently.
    clr(); s.wbv = 1; s.wbn = 6; s.luv = 1; s.lun = 13; s.lud = 32'h13; drive_chk(); tick();
    clr(); s.wbv = 1; s.wbn = 0; s.wbd = 32'hFFFF; s.iss = 1; s.issn = 0; drive_chk();
    chk("t5_head_wn", 32'(bus.rf_wn), 32'd13);
    tick();
    clr(); s.luv = 1; s.lun = 0; s.lud = 32'h55; drive_chk();
    chk("t5_r0_stall", 32'(bus.id_stall), 32'd0);
    tick();
    clr(); drive_chk(); chk("t5_r0_head_we", 32'(bus.rf_we), 32'd0); tick();

    // Asynchronous reset mid-cycle with one buffered entry and r7 pending.
    clr(); s.iss = 1; s.issn = 7; s.wbv = 1; s.wbn = 4; drive_chk(); tick();
    clr(); s.wbv = 1; s.wbn = 4; s.luv = 1; s.lun = 7; s.lud = 32'h77; drive_chk(); tick();
    @(negedge clk);
    clr(); s.rn1 = 7; apply();
    #1;
    chk("t6_pre_stall", 32'(bus.id_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("t6_id_stall", 32'(bus.id_stall), 32'd0);
    chk("t6_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t6_rf_wn", 32'(bus.rf_wn), 32'd0);
    chk("t6_rf_wd", bus.rf_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      clr(); s.rn1 = 7; drive_chk();
      chk("t6_no_r7_write", 32'(bus.rf_we), 32'd0);
      tick();
    end

    // Randomized traffic: light WB load, then heavy load to provoke starvation.
    for (int i = 0; i < 400; i++) begin
      clr();
      s.wbv  = ($urandom_range(0, 99) < ((i < 200) ? 45 : 85));
      s.wbn  = 5'($urandom_range(0, 31));
      s.wbd  = $urandom();
      s.issn = 5'($urandom_range(0, 31));
      s.iss  = ($urandom_range(0, 3) == 0) && !mpend[s.issn];
      s.luv  = 1'($urandom_range(0, 1));
      s.lun  = 5'($urandom_range(0, 31));
      s.lud  = $urandom();
      s.rn1  = 5'($urandom_range(0, 31));
      s.rn2  = 5'($urandom_range(0, 31));
      s.idwn = 5'($urandom_range(0, 31));
      drive_chk();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
